psum_accumulator: RTL and testbench

- Sits directly downstream of the CIM macro.
- Consumes the macro's 8-lane, 14-bit unsigned partial-sum vector once per input-channel tile and accumulates it across a programmable number of tiles.
- Emits the 8-lane result through a one-entry output register with a valid/ready handshake.
- Lets a layer wider than 64 input channels be computed as several macro passes.

---
 rtl/psum_accumulator.sv | 100 ++++++++++
 tb/tb_psum_accumulator.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Accumulates the CIM macro's per-lane partial sums over a programmable number of
// input-channel tiles and presents each completed group through a one-entry valid/ready output.
module psum_accumulator #(
    parameter int LANES  = 8,
    parameter int PSUM_W = 14,
    parameter int ACC_W  = 18,
    parameter int CNT_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [CNT_W-1:0]         num_tiles,
    input  logic                     psum_valid,
    output logic                     psum_ready,
    input  logic [LANES*PSUM_W-1:0]  psum_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   acc_out,
    output logic [CNT_W-1:0]         tile_idx,
    output logic                     busy
);

    logic [ACC_W-1:0] r_acc     [LANES];
    logic [ACC_W-1:0] r_acc_out [LANES];
    logic [ACC_W-1:0] w_sum     [LANES];
    logic [CNT_W-1:0] r_tile_idx;
    logic [CNT_W-1:0] r_lim;
    logic [CNT_W-1:0] w_lim_eff;
    logic             r_out_valid;
    logic             w_ready;
    logic             w_accept;
    logic             w_first;
    logic             w_last;

    assign w_ready   = !r_out_valid || out_ready;
    assign w_accept  = psum_valid && w_ready;
    assign w_first   = (r_tile_idx == '0);
    // The group length is taken live on the first beat so a one-tile group completes immediately.
    assign w_lim_eff = w_first ? num_tiles : r_lim;
    assign w_last    = (r_tile_idx == w_lim_eff);

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            logic [PSUM_W-1:0] w_psum;
            logic [ACC_W:0]    w_wide;

            assign w_psum   = psum_in[PSUM_W*g+PSUM_W-1 -: PSUM_W];
            assign w_wide   = {1'b0, r_acc[g]} + (ACC_W+1)'(w_psum);
            assign w_sum[g] = w_first ? ACC_W'(w_psum)
                            : (w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0]);
            assign acc_out[ACC_W*g+ACC_W-1 -: ACC_W] = r_acc_out[g];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_acc[i]     <= '0;
                r_acc_out[i] <= '0;
            end
            r_tile_idx  <= '0;
            r_lim       <= '0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < LANES; i++) begin
                r_acc[i] <= '0;
            end
            r_tile_idx  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                for (int i = 0; i < LANES; i++) begin
                    r_acc[i] <= w_sum[i];
                end
                if (w_first) begin
                    r_lim <= num_tiles;
                end
                if (w_last) begin
                    for (int i = 0; i < LANES; i++) begin
                        r_acc_out[i] <= w_sum[i];
                    end
                    r_out_valid <= 1'b1;
                    r_tile_idx  <= '0;
                end else begin
                    r_tile_idx <= r_tile_idx + 1'b1;
                end
            end
        end
    end

    assign psum_ready = w_ready;
    assign out_valid  = r_out_valid;
    assign tile_idx   = r_tile_idx;
    assign busy       = (r_tile_idx != '0);

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: default build (a) plus an ACC_W=15 build (b) for saturation.
module tb_psum_accumulator;

    localparam int LANES  = 8;
    localparam int PSUM_W = 14;
    localparam int CNT_W  = 4;
    localparam int AW_A   = 18;
    localparam int AW_B   = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic                    a_clear = 1'b0, a_valid = 1'b0, a_oready = 1'b1;
    logic [CNT_W-1:0]        a_ntiles = '0;
    logic [LANES*PSUM_W-1:0] a_psum = '0;
    logic                    a_pready, a_ovalid, a_busy;
    logic [LANES*AW_A-1:0]   a_acc;
    logic [CNT_W-1:0]        a_tidx;

    logic                    b_clear = 1'b0, b_valid = 1'b0, b_oready = 1'b1;
    logic [CNT_W-1:0]        b_ntiles = '0;
    logic [LANES*PSUM_W-1:0] b_psum = '0;
    logic                    b_pready, b_ovalid, b_busy;
    logic [LANES*AW_B-1:0]   b_acc;
    logic [CNT_W-1:0]        b_tidx;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    psum_accumulator #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(AW_A), .CNT_W(CNT_W)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(a_clear), .num_tiles(a_ntiles),
        .psum_valid(a_valid), .psum_ready(a_pready), .psum_in(a_psum),
        .out_valid(a_ovalid), .out_ready(a_oready), .acc_out(a_acc),
        .tile_idx(a_tidx), .busy(a_busy));

    psum_accumulator #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(AW_B), .CNT_W(CNT_W)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(b_clear), .num_tiles(b_ntiles),
        .psum_valid(b_valid), .psum_ready(b_pready), .psum_in(b_psum),
        .out_valid(b_ovalid), .out_ready(b_oready), .acc_out(b_acc),
        .tile_idx(b_tidx), .busy(b_busy));

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*PSUM_W-1:0] psum_all(input int v);
        logic [LANES*PSUM_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[PSUM_W*i +: PSUM_W] = PSUM_W'(v);
        return r;
    endfunction

    function automatic logic [LANES*AW_A-1:0] acc_a(input int v, input int step);
        logic [LANES*AW_A-1:0] r;
        for (int i = 0; i < LANES; i++) r[AW_A*i +: AW_A] = AW_A'(v + step*i);
        return r;
    endfunction

    function automatic logic [LANES*AW_B-1:0] acc_b(input int v);
        logic [LANES*AW_B-1:0] r;
        for (int i = 0; i < LANES; i++) r[AW_B*i +: AW_B] = AW_B'(v);
        return r;
    endfunction

    initial begin
        // reset
        repeat (2) tick();
        chk("rst_ovalid", a_ovalid, 0);
        chk("rst_tidx",   a_tidx,   0);
        chk("rst_busy",   a_busy,   0);
        chk("rst_pready", a_pready, 1);
        chk("rst_acc",    a_acc,    0);
        rst_n = 1'b1;
        tick();

        // single tile
        a_ntiles = 0; a_psum = psum_all(100); a_valid = 1; a_oready = 1;
        tick();
        a_valid = 0;
        chk("single_ovalid", a_ovalid, 1);
        chk("single_acc",    a_acc,    acc_a(100, 0));
        tick();
        chk("single_drop",   a_ovalid, 0);

        // four tiles, lane-dependent first beat, num_tiles change mid-group ignored
        a_ntiles = 3;
        for (int i = 0; i < LANES; i++) a_psum[PSUM_W*i +: PSUM_W] = PSUM_W'(i);
        a_valid = 1;
        tick();
        chk("four_tidx1", a_tidx, 1);
        chk("four_busy1", a_busy, 1);
        a_psum = psum_all(1000);
        tick();
        chk("four_tidx2", a_tidx, 2);
        a_ntiles = 7;
        a_psum = psum_all(16383);
        tick();
        chk("four_tidx3", a_tidx, 3);
        chk("four_noout", a_ovalid, 0);
        a_psum = psum_all(5);
        tick();
        a_valid = 0;
        chk("four_ovalid", a_ovalid, 1);
        chk("four_acc",    a_acc,    acc_a(17388, 1));
        chk("four_busy",   a_busy,   0);
        chk("four_tidx0",  a_tidx,   0);
        tick();
        chk("four_drop",   a_ovalid, 0);

        // backpressure
        a_ntiles = 0; a_oready = 0; a_psum = psum_all(200); a_valid = 1;
        tick();
        chk("bp_ovalid", a_ovalid, 1);
        chk("bp_acc0",   a_acc,    acc_a(200, 0));
        a_psum = psum_all(300);
        #1;
        chk("bp_pready0", a_pready, 0);
        tick();
        chk("bp_hold_acc", a_acc,    acc_a(200, 0));
        chk("bp_hold_ov",  a_ovalid, 1);
        chk("bp_hold_tid", a_tidx,   0);
        a_oready = 1;
        #1;
        chk("bp_pready1", a_pready, 1);
        tick();
        a_valid = 0;
        chk("bp_new_acc", a_acc,    acc_a(300, 0));
        chk("bp_new_ov",  a_ovalid, 1);
        tick();
        chk("bp_drop",    a_ovalid, 0);

        // back-to-back single-tile groups
        a_ntiles = 0; a_oready = 1; a_valid = 1;
        for (int k = 0; k < 4; k++) begin
            a_psum = psum_all(10 + 7*k);
            tick();
            chk("b2b_ovalid", a_ovalid, 1);
            chk("b2b_acc",    a_acc,    acc_a(10 + 7*k, 0));
        end
        a_valid = 0;
        tick();
        chk("b2b_drop", a_ovalid, 0);

        // abort mid-group with a valid beat present
        a_ntiles = 3; a_valid = 1;
        a_psum = psum_all(50); tick();
        a_psum = psum_all(60); tick();
        chk("abort_tidx2", a_tidx, 2);
        a_clear = 1; a_psum = psum_all(70);
        tick();
        a_clear = 0;
        chk("abort_tidx",  a_tidx,   0);
        chk("abort_busy",  a_busy,   0);
        chk("abort_ov",    a_ovalid, 0);
        for (int k = 1; k <= 4; k++) begin
            a_psum = psum_all(k);
            tick();
        end
        a_valid = 0;
        chk("abort_ov2",  a_ovalid, 1);
        chk("abort_acc",  a_acc,    acc_a(10, 0));
        tick();

        // saturation on the narrow build
        b_ntiles = 2; b_psum = psum_all(16383); b_valid = 1; b_oready = 1;
        repeat (3) tick();
        b_valid = 0;
        chk("sat_ov",  b_ovalid, 1);
        chk("sat_acc", b_acc,    acc_b(32767));
        tick();

        // asynchronous reset mid-group: a holds a result, b is mid-group
        a_ntiles = 0; a_oready = 0; a_psum = psum_all(123); a_valid = 1;
        b_ntiles = 2; b_psum = psum_all(9); b_valid = 1;
        tick();
        a_valid = 0; b_valid = 0;
        chk("ar_pre_ov",   a_ovalid, 1);
        chk("ar_pre_tidx", b_tidx,   1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_ov",    a_ovalid, 0);
        chk("ar_acc",   a_acc,    0);
        chk("ar_tidx",  b_tidx,   0);
        chk("ar_busy",  b_busy,   0);
        chk("ar_pready", a_pready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
